// File: rtl/flash_prog_ctrl.sv
// Program/erase sequencer for a dual 16-bit parallel flash pair sharing one 32-bit bus.
// Optional build macro FLASH_UNLOCK_EN prefixes each block erase with a block-unlock sequence.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for req
// ARB      | bus_req raised, waiting for pin-mux grant
// UNLK1/2  | block unlock (0x60, 0xD0), erase only, FLASH_UNLOCK_EN builds
// CMD1     | program setup 0x40 / erase setup 0x20
// CMD2     | program data / erase confirm 0xD0
// WAIT_RDY | 16-cycle blanking, then poll ready with timeout
// SR_CMD   | read-status command 0x70
// SR_RD    | bus read of both status registers
// SR_CLR   | clear status 0x50, only after a device error
// RD_ARRAY | return to read-array mode 0xFF
// DONE     | one-cycle completion pulse, bus released
module flash_prog_ctrl #(
    parameter int CLK_FREQ   = 100,
    parameter int ADDR_BITS  = 25,
    parameter int T_WP_NS    = 60,
    parameter int T_WPH_NS   = 30,
    parameter int T_RD_NS    = 110,
    parameter int TIMEOUT_US = 5000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 cmd,
    input  logic [ADDR_BITS-3:0] addr,
    input  logic [31:0]          data,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err_code,
    output logic [15:0]          status,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output logic [1:0]           flash_ce_n,
    output logic                 flash_oe_n,
    output logic                 flash_we_n,
    output logic [ADDR_BITS-3:0] flash_addr,
    output logic [31:0]          flash_dout,
    output logic                 flash_dout_en,
    input  logic [31:0]          flash_din,
    input  logic [1:0]           flash_ready
);

    localparam int WP_RAW  = (CLK_FREQ * T_WP_NS + 999) / 1000;
    localparam int WPH_RAW = (CLK_FREQ * T_WPH_NS + 999) / 1000;
    localparam int RD_RAW  = (CLK_FREQ * T_RD_NS + 999) / 1000;
    localparam int WP_CYC  = (WP_RAW < 1) ? 1 : WP_RAW;
    localparam int WPH_CYC = (WPH_RAW < 1) ? 1 : WPH_RAW;
    localparam int RD_CYC  = (RD_RAW < 1) ? 1 : RD_RAW;
    localparam int WR_LEN  = 1 + WP_CYC + WPH_CYC;
    localparam int RD_LEN  = RD_CYC + 1;
    localparam int PH_MAX  = (WR_LEN > RD_LEN) ? WR_LEN : RD_LEN;
    localparam int PH_W    = $clog2(PH_MAX);

    localparam longint TO_CYC = longint'(CLK_FREQ) * longint'(TIMEOUT_US);
    localparam int     TMR_W  = $clog2(TO_CYC + 1);

    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TO_CYC - 1);
    localparam logic [PH_W-1:0]  WR_LAST  = PH_W'(WR_LEN - 1);
    localparam logic [PH_W-1:0]  WP_END   = PH_W'(WP_CYC);
    localparam logic [PH_W-1:0]  RD_CAP   = PH_W'(RD_CYC - 1);
    localparam logic [PH_W-1:0]  RD_END   = PH_W'(RD_CYC);
    localparam logic [4:0]       BLANK_LOAD = 5'd16;
    localparam logic [7:0]       SR_ERR_MASK = 8'h3A;

    localparam logic [31:0] W_UNLOCK  = 32'h0060_0060;
    localparam logic [31:0] W_CONFIRM = 32'h00D0_00D0;
    localparam logic [31:0] W_ERASE   = 32'h0020_0020;
    localparam logic [31:0] W_PROG    = 32'h0040_0040;
    localparam logic [31:0] W_RDSR    = 32'h0070_0070;
    localparam logic [31:0] W_CLRSR   = 32'h0050_0050;
    localparam logic [31:0] W_RDARR   = 32'h00FF_00FF;

    typedef enum logic [3:0] {
        IDLE, ARB, UNLK1, UNLK2, CMD1, CMD2, WAIT_RDY,
        SR_CMD, SR_RD, SR_CLR, RD_ARRAY, DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [PH_W-1:0]        phase;
    logic [TMR_W-1:0]       tmr;
    logic [4:0]             blank;
    logic                   cmd_q;
    logic [ADDR_BITS-3:0]   addr_q;
    logic [31:0]            data_q;
    logic                   to_hit;
    logic                   wr_last;
    logic                   is_wr;
    logic [31:0]            wr_word;
    logic [7:0]             sr_any;
    logic                   unused_din;

    assign wr_last    = (phase == WR_LAST);
    assign sr_any     = flash_din[23:16] | flash_din[7:0];
    assign unused_din = ^{flash_din[31:24], flash_din[15:8]};

    always_comb begin
        state_nxt = state;
        to_hit    = 1'b0;
        case (state)
            IDLE:     if (req) state_nxt = ARB;
            ARB: begin
                if (bus_gnt) begin
`ifdef FLASH_UNLOCK_EN
                    state_nxt = cmd_q ? UNLK1 : CMD1;
`else
                    state_nxt = CMD1;
`endif
                end
            end
            UNLK1:    if (wr_last) state_nxt = UNLK2;
            UNLK2:    if (wr_last) state_nxt = CMD1;
            CMD1:     if (wr_last) state_nxt = CMD2;
            CMD2:     if (wr_last) state_nxt = WAIT_RDY;
            WAIT_RDY: begin
                if ((blank == '0) && (&flash_ready)) begin
                    state_nxt = SR_CMD;
                end else if (tmr == '0) begin
                    to_hit    = 1'b1;
                    state_nxt = RD_ARRAY;
                end
            end
            SR_CMD:   if (wr_last) state_nxt = SR_RD;
            SR_RD: begin
                // err_code was updated at the capture cycle, so it is valid here
                if (phase == RD_END) state_nxt = (err_code == 2'b01) ? SR_CLR : RD_ARRAY;
            end
            SR_CLR:   if (wr_last) state_nxt = RD_ARRAY;
            RD_ARRAY: if (wr_last) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        is_wr   = 1'b1;
        wr_word = '0;
        case (state)
            UNLK1:    wr_word = W_UNLOCK;
            UNLK2:    wr_word = W_CONFIRM;
            CMD1:     wr_word = cmd_q ? W_ERASE : W_PROG;
            CMD2:     wr_word = cmd_q ? W_CONFIRM : data_q;
            SR_CMD:   wr_word = W_RDSR;
            SR_CLR:   wr_word = W_CLRSR;
            RD_ARRAY: wr_word = W_RDARR;
            default:  is_wr = 1'b0;
        endcase
    end

    always_comb begin
        flash_ce_n    = 2'b11;
        flash_oe_n    = 1'b1;
        flash_we_n    = 1'b1;
        flash_addr    = '0;
        flash_dout    = '0;
        flash_dout_en = 1'b0;
        if (is_wr && bus_gnt) begin
            flash_addr = addr_q;
            flash_dout = wr_word;
            if (!wr_last) begin
                flash_ce_n    = 2'b00;
                flash_dout_en = 1'b1;
                flash_we_n    = !((phase != '0) && (phase <= WP_END));
            end
        end else if ((state == SR_RD) && bus_gnt) begin
            flash_addr = addr_q;
            if (phase < RD_END) begin
                flash_ce_n = 2'b00;
                flash_oe_n = 1'b0;
            end
        end
    end

    assign busy    = (state != IDLE) && (state != DONE);
    assign bus_req = busy;
    assign done    = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= '0;
            tmr      <= TMR_LOAD;
            blank    <= BLANK_LOAD;
            cmd_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            err_code <= 2'b00;
            status   <= '0;
        end else begin
            state <= state_nxt;
            phase <= (state_nxt != state) ? '0 : phase + 1'b1;

            if ((state == IDLE) && req) begin
                cmd_q    <= cmd;
                addr_q   <= addr;
                data_q   <= data;
                err_code <= 2'b00;
                status   <= '0;
            end

            // timeout and blanking counters reload whenever the poll state is left
            if (state == WAIT_RDY) begin
                if (tmr != '0)   tmr   <= tmr - 1'b1;
                if (blank != '0) blank <= blank - 1'b1;
            end else begin
                tmr   <= TMR_LOAD;
                blank <= BLANK_LOAD;
            end

            if (to_hit) err_code <= 2'b10;

            if ((state == SR_RD) && (phase == RD_CAP)) begin
                status <= {flash_din[23:16], flash_din[7:0]};
                if ((sr_any & SR_ERR_MASK) != '0) err_code <= 2'b01;
            end
        end
    end

endmodule
